uart_rx_frame_ctrl: RTL and testbench

Receive-side frame sequencer for the UART Rx path. Walks each incoming frame through start, data, even-parity and stop stages using a 16x oversample tick, and assembles the data word LSB-first. Drives the parity-stage strobe and the parity/framing verdicts, and hands a completed word to the downstream Rx consumer. Sits between the input synchroniser and the Rx data sink.

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 27 ++
 rtl/uart_rx_frame_ctrl_rx_bit_timer.sv | 38 +++
 rtl/uart_rx_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and sizing helpers for the UART Rx frame sequencer.
package uart_rx_frame_ctrl_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam int unsigned TICK_CNT_W_DEF = $clog2(OVERSAMPLE_DEF);
  localparam int unsigned BIT_IDX_W_DEF  = $clog2(DATA_WIDTH_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  function automatic int unsigned tick_cnt_w(input int unsigned oversample);
    return $clog2(oversample);
  endfunction

  function automatic int unsigned bit_idx_w(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_rx_bit_timer.sv
// Oversample tick counter; flags the mid-start-bit and mid-data-bit sample points.
module uart_rx_frame_ctrl_rx_bit_timer
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic clear_i,
  output logic mid_start_o,
  output logic mid_bit_o
);

  localparam int unsigned CW = tick_cnt_w(OVERSAMPLE);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      cnt_d = clear_i ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Strobes are qualified by the tick so the FSM can act on them directly.
  assign mid_start_o = tick_i && (cnt_q == CW'(OVERSAMPLE / 2 - 1));
  assign mid_bit_o   = tick_i && (cnt_q == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART Rx frame sequencer: start / data (LSB first) / even parity / stop, with
// parity and framing verdicts held from one completed frame to the next.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned OVERSAMPLE       = OVERSAMPLE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in_synced,
  input  logic                        baud_tick,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        frame_done,
  output logic                        rx_error,
  output logic                        framing_error,
  output logic                        is_parity_stage,
  output logic                        busy
);

  localparam int unsigned W  = INPUT_DATA_WIDTH;
  localparam int unsigned BW = bit_idx_w(INPUT_DATA_WIDTH);

  rx_state_e      state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   data_q, data_d;
  logic [BW-1:0]  bit_idx_q, bit_idx_d;
  logic           par_err_q, par_err_d;
  logic           done_q, done_d;
  logic           rx_err_q, rx_err_d;
  logic           frm_err_q, frm_err_d;

  logic           tmr_clear;
  logic           mid_start;
  logic           mid_bit;

  uart_rx_frame_ctrl_rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (baud_tick),
    .clear_i     (tmr_clear),
    .mid_start_o (mid_start),
    .mid_bit_o   (mid_bit)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    par_err_d = par_err_q;
    rx_err_d  = rx_err_q;
    frm_err_d = frm_err_q;
    done_d    = 1'b0;
    tmr_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (baud_tick && !serial_in_synced) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (mid_start) begin
          tmr_clear = 1'b1;
          if (serial_in_synced) begin
            state_d = ST_IDLE;
          end else begin
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (mid_bit) begin
          tmr_clear = 1'b1;
          shift_d   = {serial_in_synced, shift_q[W-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BW'(W - 1)) begin
            state_d = ST_PARITY;
          end
        end
      end

      ST_PARITY: begin
        if (mid_bit) begin
          tmr_clear = 1'b1;
          par_err_d = serial_in_synced ^ (^shift_q);
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (mid_bit) begin
          tmr_clear = 1'b1;
          done_d    = 1'b1;
          data_d    = shift_q;
          rx_err_d  = par_err_q;
          frm_err_d = ~serial_in_synced;
          // A low stop bit means the line is stuck low; wait it out in BREAK.
          state_d   = serial_in_synced ? ST_IDLE : ST_BREAK;
        end
      end

      ST_BREAK: begin
        tmr_clear = 1'b1;
        if (baud_tick && serial_in_synced) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      data_q    <= '0;
      bit_idx_q <= '0;
      par_err_q <= 1'b0;
      done_q    <= 1'b0;
      rx_err_q  <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      par_err_q <= par_err_d;
      done_q    <= done_d;
      rx_err_q  <= rx_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign received_data   = data_q;
  assign frame_done      = done_q;
  assign rx_error        = rx_err_q;
  assign framing_error   = frm_err_q;
  assign is_parity_stage = (state_q == ST_PARITY);
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a frame-level expectation queue.
module tb_uart_rx_frame_ctrl;

  localparam int W        = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  // First start-bit tick to the tick count seen alongside frame_done:
  // half a bit to mid-start, 10 more bit periods to mid-stop, plus that edge.
  localparam int DONE_OFS    = OS / 2 + (W + 2) * OS + 1;
  // start + data + parity + stop
  localparam int FRAME_TICKS = (W + 3) * OS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         serial_in_synced = 1'b1;
  logic         baud_tick = 1'b0;
  logic [W-1:0] received_data;
  logic         frame_done;
  logic         rx_error;
  logic         framing_error;
  logic         is_parity_stage;
  logic         busy;

  uart_rx_frame_ctrl #(
    .INPUT_DATA_WIDTH (W),
    .OVERSAMPLE       (OS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .serial_in_synced (serial_in_synced),
    .baud_tick        (baud_tick),
    .received_data    (received_data),
    .frame_done       (frame_done),
    .rx_error         (rx_error),
    .framing_error    (framing_error),
    .is_parity_stage  (is_parity_stage),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Edge-side bookkeeping
  int   tick_num = 0;
  int   par_ticks = 0;
  logic rst_edge = 1'b1;
  logic tick_at_edge = 1'b0;

  always @(posedge clk) begin
    rst_edge     <= reset;
    tick_at_edge <= baud_tick;
    if (baud_tick) tick_num <= tick_num + 1;
    if (baud_tick && is_parity_stage) par_ticks <= par_ticks + 1;
  end

  // Frame-level model: what the line carried decides every verdict.
  typedef struct {
    logic [W-1:0] data;
    logic         perr;
    logic         ferr;
    int           done_tick;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] m_data = '0;
  logic         m_perr = 1'b0;
  logic         m_ferr = 1'b0;
  int           done_cnt = 0;
  int           done_ticks[$];
  logic [W-1:0] done_data[$];
  logic         mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) begin
        m_data = '0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        chk("frame_done_after_reset", 32'(frame_done), 32'd0);
      end else if (frame_done) begin
        done_cnt++;
        done_ticks.push_back(tick_num);
        done_data.push_back(received_data);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_done: got pulse expected none at time %0t", $time);
        end else begin
          mon_e  = exp_q.pop_front();
          m_data = mon_e.data;
          m_perr = mon_e.perr;
          m_ferr = mon_e.ferr;
          chk("done_tick", 32'(tick_num), 32'(mon_e.done_tick));
          chk("done_one_clk_after_tick", 32'(tick_at_edge), 32'd1);
        end
      end
      chk("received_data", 32'(received_data), 32'(m_data));
      chk("rx_error", 32'(rx_error), 32'(m_perr));
      chk("framing_error", 32'(framing_error), 32'(m_ferr));
    end
  end

  task automatic tick_edge();
    do @(posedge clk); while (!baud_tick);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    serial_in_synced = v;
    repeat (OS) tick_edge();
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stp);
    exp_t e;
    e.data      = d;
    e.perr      = par ^ (^d);
    e.ferr      = ~stp;
    e.done_tick = tick_num + DONE_OFS;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int d0;
  int p0;
  int n;
  int diff;
  logic [7:0] d3c;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_received_data", 32'(received_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rx_error", 32'(rx_error), 32'd0);
    chk("rst_framing_error", 32'(framing_error), 32'd0);
    chk("rst_parity_stage", 32'(is_parity_stage), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    // 0xA5, even parity 0, good stop
    d0 = done_cnt;
    p0 = par_ticks;
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("a5_done_count", 32'(done_cnt - d0), 32'd1);
    chk("a5_data", 32'(received_data), 32'hA5);
    chk("a5_rx_error", 32'(rx_error), 32'd0);
    chk("a5_framing_error", 32'(framing_error), 32'd0);
    chk("a5_parity_ticks", 32'(par_ticks - p0), 32'd16);

    // 0x07 with parity bit 0 (correct would be 1), then a good 0x00
    send_frame(8'h07, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("07_data", 32'(received_data), 32'h07);
    chk("07_rx_error", 32'(rx_error), 32'd1);
    chk("07_framing_error", 32'(framing_error), 32'd0);
    send_frame(8'h00, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("00_data", 32'(received_data), 32'h00);
    chk("00_rx_error_cleared", 32'(rx_error), 32'd0);

    // Short low glitch: 6 ticks low, rejected at the mid-start sample
    d0 = done_cnt;
    serial_in_synced = 1'b0;
    repeat (6) tick_edge();
    serial_in_synced = 1'b1;
    repeat (2) tick_edge();
    chk("glitch_busy_before_mid", 32'(busy), 32'd1);
    tick_edge();
    chk("glitch_busy_after_mid", 32'(busy), 32'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);

    // Break: line low for 20 bit times
    d0 = done_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (20 - (W + 3)) send_bit(1'b0);
    chk("break_done_count", 32'(done_cnt - d0), 32'd1);
    chk("break_data", 32'(received_data), 32'h00);
    chk("break_framing_error", 32'(framing_error), 32'd1);
    chk("break_rx_error", 32'(rx_error), 32'd0);
    chk("break_busy_held", 32'(busy), 32'd1);
    serial_in_synced = 1'b1;
    tick_edge();
    chk("break_busy_released", 32'(busy), 32'd0);
    repeat (3) send_bit(1'b1);
    chk("break_no_extra_done", 32'(done_cnt - d0), 32'd1);

    // Reset for one clk in the middle of data bit 3 of 0x3C
    d0 = done_cnt;
    d3c = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d3c[i]);
    serial_in_synced = d3c[3];
    repeat (OS / 2) tick_edge();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_received_data", 32'(received_data), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_rx_error", 32'(rx_error), 32'd0);
    chk("midrst_framing_error", 32'(framing_error), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    serial_in_synced = 1'b1;
    repeat (W + 3) send_bit(1'b1);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("3c_data", 32'(received_data), 32'h3C);
    chk("3c_rx_error", 32'(rx_error), 32'd0);
    chk("3c_done_count", 32'(done_cnt - d0), 32'd1);

    // Back-to-back 0x55, 0xAA with no idle gap
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    n = done_ticks.size();
    if (n >= 2) begin
      diff = done_ticks[n-1] - done_ticks[n-2];
      chk("b2b_spacing_ok", 32'(diff >= FRAME_TICKS - 1 && diff <= FRAME_TICKS + 1), 32'd1);
      chk("b2b_first_data", 32'(done_data[n-2]), 32'h55);
      chk("b2b_second_data", 32'(done_data[n-1]), 32'hAA);
    end else begin
      checks++;
      failures++;
      $display("FAIL b2b_pulses: got %0d expected at least 2", n);
    end
    chk("all_frames_seen", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
